multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the 16-bit MIPS datapath: steps each instruction through

---
 rtl/mips16_ctrl_pkg.sv | 64 ++++++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_ctrl_pkg.sv
// Shared definitions for the 16-bit MIPS multi-cycle controller: opcodes, ALU codes,
// state encodings and wait-timer bounds.
package mips16_ctrl_pkg;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAddi = 4'b0010;
  localparam logic [3:0] OpLw   = 4'b0011;
  localparam logic [3:0] OpSw   = 4'b0100;
  localparam logic [3:0] OpJmp  = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpOr   = 4'b0111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAddi = 4'b0010;
  localparam logic [3:0] AluLw   = 4'b0011;
  localparam logic [3:0] AluSw   = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluOr   = 4'b0111;

  localparam int unsigned TimeoutMin = 1;
  localparam int unsigned TimeoutMax = 255;
  localparam int unsigned TimerW     = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StJmp    = 3'd6,
    StTrap   = 3'd7
  } state_e;

  function automatic logic is_rtype(logic [3:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpXor) || (op == OpOr);
  endfunction

  function automatic logic uses_imm(logic [3:0] op);
    return (op == OpAddi) || (op == OpLw) || (op == OpSw);
  endfunction

  function automatic logic is_illegal(logic [3:0] op);
    return !(is_rtype(op) || uses_imm(op) || (op == OpJmp));
  endfunction

  function automatic logic [3:0] alu_code(logic [3:0] op);
    logic [3:0] code;
    code = AluAdd;
    unique case (op)
      OpSub:   code = AluSub;
      OpAddi:  code = AluAddi;
      OpLw:    code = AluLw;
      OpSw:    code = AluSw;
      OpXor:   code = AluXor;
      OpOr:    code = AluOr;
      default: code = AluAdd;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; timeout_o flags the cycle in which the count reaches Limit.
module mem_wait_timer
  import mips16_ctrl_pkg::*;
#(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [TimerW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the stalled cycle that would bring the count up to Limit.
  assign timeout_o = en_i && (count_q == TimerW'(Limit - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Build option: define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_ctrl_fsm
  import mips16_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUOPW  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ir_write,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              jump,
  output logic [ALUOPW-1:0] alu_op,
  output logic              instr_done,
  output logic              bus_err,
  output logic [2:0]        state_o
);

  if (TIMEOUT < TimeoutMin || TIMEOUT > TimeoutMax) begin : g_bad_timeout
    $error("TIMEOUT must lie within the wait timer range");
  end

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           bus_err_q, bus_err_d;
  logic           wait_en, wait_clr, timeout;

  assign wait_en  = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .Limit(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    jump       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run && !bus_err_q) state_d = StFetch;
      end
      StFetch: begin
        mem_read = 1'b1;
        pc_write = mem_ready;
        ir_write = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        if (opcode == OpJmp) begin
          state_d = StJmp;
        end else if (is_illegal(opcode)) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          instr_done = 1'b1;
          state_d    = run ? StFetch : StIdle;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = ((op_q == OpLw) || (op_q == OpSw)) ? StMem : StWb;
      end
      StMem: begin
        iord      = 1'b1;
        mem_read  = (op_q == OpLw);
        mem_write = (op_q == OpSw);
        if (mem_ready) begin
          if (op_q == OpSw) begin
            instr_done = 1'b1;
            state_d    = run ? StFetch : StIdle;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype(op_q);
        mem_to_reg = (op_q == OpLw);
        instr_done = 1'b1;
        state_d    = run ? StFetch : StIdle;
      end
      StJmp: begin
        jump       = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? StFetch : StIdle;
      end
      StTrap: begin
        state_d = StTrap;
      end
    endcase

    // ALU controls stay valid for the whole datapath phase of the instruction.
    if ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) begin
      alu_op  = ALUOPW'(alu_code(op_q));
      alu_src = uses_imm(op_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
      if (state_q == StDecode) op_q <= opcode;
    end
  end

  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: vector table, directed corner sequences and a
// randomized run against an instruction-level phase-plan model.
module tb_multicycle_ctrl_fsm;
  import mips16_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 15;
`ifdef ILLEGAL_TRAP_EN
  localparam int unsigned OpMax = 7;
`else
  localparam int unsigned OpMax = 15;
`endif

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready;
  logic [3:0] opcode;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_dst, alu_src;
  logic       mem_to_reg, reg_write, jump, instr_done, bus_err;
  logic [3:0] alu_op;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .OPW    (4),
    .ALUOPW (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .iord      (iord),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .jump      (jump),
    .alu_op    (alu_op),
    .instr_done(instr_done),
    .bus_err   (bus_err),
    .state_o   (state_o)
  );

  // Control bits: {pc_write, ir_write, iord, mem_read, mem_write, reg_dst, alu_src, mem_to_reg,
  //                reg_write, jump, instr_done, bus_err, alu_op[3:0]}
  function automatic logic [15:0] dut_ctl();
    return {pc_write, ir_write, iord, mem_read, mem_write, reg_dst, alu_src, mem_to_reg,
            reg_write, jump, instr_done, bus_err, alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] o, input logic y);
    @(negedge clk);
    run       = r;
    opcode    = o;
    mem_ready = y;
    #1;
  endtask

  // ---------------- reference model: remaining phases of the current instruction ----------------
  typedef state_e phq_t[$];
  phq_t       plan;
  logic [3:0] m_op;
  logic       m_err;
  int         m_wait;

  function automatic phq_t expand(input logic [3:0] op);
    phq_t q;
    q = {};
    if (op == 4'd5) begin
      q.push_back(StJmp);
    end else if (op >= 4'd8) begin
`ifdef ILLEGAL_TRAP_EN
      q.push_back(StTrap);
`endif
    end else begin
      q.push_back(StExec);
      if (op == 4'd3 || op == 4'd4) q.push_back(StMem);
      if (op != 4'd4) q.push_back(StWb);
    end
    return q;
  endfunction

  function automatic state_e m_phase();
    return (plan.size() == 0) ? StIdle : plan[0];
  endfunction

  function automatic logic [15:0] m_ctl(input logic [3:0] opc, input logic rdy);
    state_e      ph;
    phq_t        rest;
    logic        last, done;
    logic [15:0] c;
    ph   = m_phase();
    rest = expand(opc);
    c    = 16'h0;
    last = (ph == StDecode) ? (rest.size() == 0) : (plan.size() == 1);
    done = last && !(ph inside {StIdle, StFetch, StTrap}) && (ph != StMem || rdy);
    case (ph)
      StFetch: begin c[15] = rdy; c[14] = rdy; c[12] = 1'b1; end
      StMem:   begin c[13] = 1'b1; c[12] = (m_op == 4'd3); c[11] = (m_op == 4'd4); end
      StWb:    begin c[10] = m_op inside {4'd0, 4'd1, 4'd6, 4'd7}; c[8] = (m_op == 4'd3);
                     c[7] = 1'b1; end
      StJmp:   begin c[15] = 1'b1; c[6] = 1'b1; end
      default: ;
    endcase
    if (ph inside {StExec, StMem, StWb}) begin
      c[9]   = m_op inside {4'd2, 4'd3, 4'd4};
      c[3:0] = m_op;
    end
    c[5] = done;
    c[4] = m_err;
    return c;
  endfunction

  task automatic model_advance(input logic r, input logic [3:0] opc, input logic rdy);
    state_e ph;
    ph = m_phase();
    if (ph == StIdle) begin
      if (r && !m_err) plan = {StFetch, StDecode};
    end else if (ph == StTrap) begin
      // stuck until reset
    end else if ((ph == StFetch || ph == StMem) && !rdy) begin
      m_wait++;
      if (m_wait == int'(TIMEOUT)) begin
        m_err  = 1'b1;
        m_wait = 0;
        plan.delete();
      end
    end else begin
      m_wait = 0;
      void'(plan.pop_front());
      if (ph == StDecode) begin
        m_op = opc;
        plan = expand(opc);
      end
      if (plan.size() == 0 && r) plan = {StFetch, StDecode};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'(StIdle));
    chk("rst_ctl", 32'(dut_ctl()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    plan.delete(); m_op = 4'h0; m_err = 1'b0; m_wait = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        run;
    logic [3:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] ctl;
  } vec_t;
  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    state_e lw_st[8];
    int     done_cnt, done_at;
    logic   r, y;
    logic [3:0] o;

    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; mem_ready = 1'b0;

    // ADD, then JMP, then SW with run dropped so the FSM parks in IDLE.
    vecs[0]  = '{1'b0, 4'h0, 1'b0, StIdle,   16'h0000};
    vecs[1]  = '{1'b1, 4'h0, 1'b0, StIdle,   16'h0000};
    vecs[2]  = '{1'b1, 4'h0, 1'b1, StFetch,  16'hD000};
    vecs[3]  = '{1'b1, 4'h0, 1'b1, StDecode, 16'h0000};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, StExec,   16'h0000};
    vecs[5]  = '{1'b1, 4'h0, 1'b1, StWb,     16'h04A0};
    vecs[6]  = '{1'b1, 4'h0, 1'b1, StFetch,  16'hD000};
    vecs[7]  = '{1'b1, 4'h5, 1'b1, StDecode, 16'h0000};
    vecs[8]  = '{1'b1, 4'h5, 1'b1, StJmp,    16'h8060};
    vecs[9]  = '{1'b1, 4'h4, 1'b1, StFetch,  16'hD000};
    vecs[10] = '{1'b1, 4'h4, 1'b1, StDecode, 16'h0000};
    vecs[11] = '{1'b1, 4'h4, 1'b1, StExec,   16'h0204};
    vecs[12] = '{1'b0, 4'h4, 1'b1, StMem,    16'h2A24};
    vecs[13] = '{1'b0, 4'h4, 1'b1, StIdle,   16'h0000};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].run, vecs[i].op, vecs[i].rdy);
      chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("tbl%0d_ctl", i), 32'(dut_ctl()), 32'(vecs[i].ctl));
    end

    // LW with three stalled MEM cycles: 8 cycles from FETCH to the done pulse.
    lw_st = '{StFetch, StDecode, StExec, StMem, StMem, StMem, StMem, StWb};
    do_reset();
    cyc(1'b1, 4'h3, 1'b0);
    done_cnt = 0; done_at = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 4'h3, (k == 0) || (k == 6));
      chk($sformatf("lw_state%0d", k), 32'(state_o), 32'(lw_st[k]));
      if (lw_st[k] == StMem) chk("lw_mem_rd_iord", 32'({mem_read, iord, mem_write}), 32'b110);
      if (lw_st[k] == StWb)
        chk("lw_wb_ctl", 32'({mem_to_reg, reg_dst, reg_write}), 32'b101);
      if (instr_done) begin done_cnt++; done_at = k + 1; end
    end
    chk("lw_done_cnt", 32'(done_cnt), 32'd1);
    chk("lw_done_cycle", 32'(done_at), 32'd8);
    cyc(1'b0, 4'h3, 1'b1);
    chk("lw_park_idle", 32'(state_o), 32'(StIdle));

    // FETCH timeout: bus_err after TIMEOUT stalled cycles, then run is ignored.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0);
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      cyc(1'b1, 4'h0, 1'b0);
      chk("to_fetch_hold", 32'({state_o, bus_err, pc_write, ir_write}),
          32'({3'(StFetch), 3'b000}));
    end
    cyc(1'b1, 4'h0, 1'b1);
    chk("to_idle_err", 32'({state_o, bus_err}), 32'({3'(StIdle), 1'b1}));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 4'h0, 1'b1);
      chk("to_run_ignored", 32'({state_o, bus_err}), 32'({3'(StIdle), 1'b1}));
    end

    // mem_ready on the timeout cycle wins.
    do_reset();
    cyc(1'b1, 4'h0, 1'b0);
    for (int k = 0; k < int'(TIMEOUT) - 1; k++) cyc(1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'h0, 1'b1);
    chk("rw_fetch_pc", 32'({state_o, pc_write, ir_write}), 32'({3'(StFetch), 2'b11}));
    cyc(1'b1, 4'h0, 1'b1);
    chk("rw_decode", 32'({state_o, bus_err}), 32'({3'(StDecode), 1'b0}));

    // MEM timeout on LW: abandon without writeback.
    do_reset();
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h3, 1'b1);
    cyc(1'b1, 4'h3, 1'b1);
    cyc(1'b1, 4'h3, 1'b1);
    for (int k = 0; k < int'(TIMEOUT); k++) cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h3, 1'b1);
    chk("memto_idle", 32'({state_o, bus_err, reg_write}), 32'({3'(StIdle), 2'b10}));

    // Illegal opcode 1010.
    do_reset();
    cyc(1'b1, 4'hA, 1'b0);
    cyc(1'b1, 4'hA, 1'b1);
    cyc(1'b1, 4'hA, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_decode_ctl", 32'(dut_ctl()), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 4'hA, 1'b1);
      chk("ill_trap_state", 32'(state_o), 32'(StTrap));
      chk("ill_trap_ctl", 32'(dut_ctl()), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ill_trap_reset", 32'(state_o), 32'(StIdle));
`else
    chk("ill_decode_ctl", 32'(dut_ctl()), 32'h0020);
    cyc(1'b1, 4'h0, 1'b1);
    chk("ill_next_fetch", 32'(state_o), 32'(StFetch));
`endif

    // Async reset during SW's MEM phase.
    do_reset();
    cyc(1'b1, 4'h4, 1'b0);
    cyc(1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'h4, 1'b0);
    chk("rst_sw_in_mem", 32'({state_o, mem_write}), 32'({3'(StMem), 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("rst_sw_state", 32'(state_o), 32'(StIdle));
    chk("rst_sw_ctl", 32'(dut_ctl()), 32'h0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 15) != 0);
      o = 4'($urandom_range(0, OpMax));
      y = ($urandom_range(0, 3) != 0);
      cyc(r, o, y);
      chk("rnd_state", 32'(state_o), 32'(m_phase()));
      chk("rnd_ctl", 32'(dut_ctl()), 32'(m_ctl(o, y)));
      model_advance(r, o, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
